// File: rtl/mandel_dispatcher.sv
// Frame scheduler for the Mandelbrot engine array: walks the raster, dispatches
// pixel coordinates to idle engines and forwards collected results downstream.
module mandel_dispatcher #(
  parameter int unsigned NUM_ENGINES = 8,
  parameter int unsigned X_PIXELS    = 640,
  parameter int unsigned Y_PIXELS    = 480
) (
  input  logic                   Engine_CLK,
  input  logic                   eRST,
  input  logic                   start,
  input  logic [31:0]            re_start,
  input  logic [31:0]            im_start,
  input  logic [31:0]            step,
  input  logic [NUM_ENGINES-1:0] available,
  input  logic [NUM_ENGINES-1:0] service_req,
  input  logic [26:0]            result_bus,
  output logic [2:0]             engine_addr,
  output logic [82:0]            in_word,
  output logic                   latch_en,
  output logic [NUM_ENGINES-1:0] req_ack,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [9:0]             pix_x,
  output logic [8:0]             pix_y,
  output logic [7:0]             pix_itr,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, SCAN, DISP, ACK, REL, DONE} state_t;
  state_t state, state_nx;

  logic [9:0]  x;
  logic [8:0]  y;
  logic [31:0] cur_re, cur_im, re0, step_r;
  logic        last_sent;
  logic [3:0]  outstanding;
  logic [2:0]  rr_ptr;
  logic [7:0]  launched;

  logic [7:0]  req8, free8, grant;
  logic [3:0]  idx;
  logic [2:0]  grant_idx, disp_idx;
  logic        grant_any, free_any;
  logic        do_collect, do_dispatch, frame_fin;

  // Engine vectors are padded to 8 bits so the 3-bit engine index is always in range.
  assign req8  = 8'(service_req);
  assign free8 = 8'(available) & ~launched;

  always_comb begin
    idx       = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      idx = 4'(rr_ptr) + 4'(i);
      if (idx >= 4'(NUM_ENGINES)) idx = idx - 4'(NUM_ENGINES);
      if (!grant_any && req8[idx[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[2:0];
      end
    end
    grant = grant_any ? (8'b1 << grant_idx) : '0;

    disp_idx = '0;
    free_any = 1'b0;
    for (int unsigned i = NUM_ENGINES; i > 0; i--) begin
      if (free8[3'(i - 1)]) begin
        free_any = 1'b1;
        disp_idx = 3'(i - 1);
      end
    end
  end

  assign frame_fin   = last_sent && (outstanding == '0);
  assign do_collect  = grant_any && (!pix_valid || pix_ready);
  assign do_dispatch = !last_sent && free_any;

  always_ff @(posedge Engine_CLK) begin
    if (eRST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? SCAN : IDLE;
      DONE:    state_nx = start ? SCAN : DONE;
      SCAN: begin
        if (frame_fin)        state_nx = DONE;
        else if (do_collect)  state_nx = ACK;
        else if (do_dispatch) state_nx = DISP;
        else                  state_nx = SCAN;
      end
      DISP:    state_nx = SCAN;
      ACK:     state_nx = REL;
      REL:     state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Engine_CLK) begin
    if (eRST) begin
      x           <= '0;
      y           <= '0;
      cur_re      <= '0;
      cur_im      <= '0;
      re0         <= '0;
      step_r      <= '0;
      last_sent   <= 1'b0;
      outstanding <= '0;
      rr_ptr      <= '0;
      launched    <= '0;
      engine_addr <= '0;
      in_word     <= '0;
      latch_en    <= 1'b0;
      req_ack     <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_itr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // A launched bit survives until the engine is seen dropping available.
      launched <= (launched & 8'(available)) |
                  ((state == DISP) ? (8'b1 << engine_addr) : '0);
      if (pix_valid && pix_ready) pix_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            re0         <= re_start;
            step_r      <= step;
            cur_re      <= re_start;
            cur_im      <= im_start;
            x           <= '0;
            y           <= '0;
            last_sent   <= 1'b0;
            outstanding <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        SCAN: begin
          if (frame_fin) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (do_collect) begin
            req_ack <= grant[NUM_ENGINES-1:0];
            rr_ptr  <= (grant_idx == 3'(NUM_ENGINES - 1)) ? '0 : grant_idx + 3'd1;
          end else if (do_dispatch) begin
            engine_addr <= disp_idx;
            in_word     <= {x, y, cur_re, cur_im};
            latch_en    <= 1'b1;
          end
        end
        DISP: begin
          latch_en    <= 1'b0;
          outstanding <= outstanding + 4'd1;
          if (x == 10'(X_PIXELS - 1)) begin
            x      <= '0;
            cur_re <= re0;
            y      <= y + 9'd1;
            cur_im <= cur_im - step_r;
            if (y == 9'(Y_PIXELS - 1)) last_sent <= 1'b1;
          end else begin
            x      <= x + 10'd1;
            cur_re <= cur_re + step_r;
          end
        end
        ACK: begin
          req_ack     <= '0;
          pix_x       <= result_bus[26:17];
          pix_y       <= result_bus[16:8];
          pix_itr     <= result_bus[7:0];
          pix_valid   <= 1'b1;
          outstanding <= outstanding - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mandel_dispatcher.md
# mandel_dispatcher

Frame-level scheduler for the Mandelbrot engine array. It walks the pixel raster, generates each pixel's fixed-point complex coordinate, and dispatches work to idle engines over the shared `engine_addr`/`in_word`/`latch_en` bus. It collects finished results over the shared 27-bit tri-state result bus using one-hot `req_ack`, and forwards each (x, y, iterations) triple to the frame-buffer writer through a valid/ready port.

## Interface
- `NUM_ENGINES`, 8: number of attached engines, 1..8.
- `X_PIXELS`, 640: columns per frame, ≤1024.
- `Y_PIXELS`, 480: rows per frame, ≤512.

- `Engine_CLK` in 1: the only clock.
- `eRST` in 1: reset, synchronous, active-high.
- `start` in 1: begin frame; sampled only in IDLE or DONE.
- `re_start` in 32: signed 8.24 real part of pixel (0,0).
- `im_start` in 32: signed 8.24 imaginary part of pixel (0,0).
- `step` in 32: signed 8.24 pixel pitch.
- `available` in NUM_ENGINES: per-engine idle flag.
- `service_req` in NUM_ENGINES: per-engine result-ready flag.
- `result_bus` in 27: shared engine output, {x[9:0], y[8:0], itr[7:0]}; valid only while a `req_ack` bit is high.
- `engine_addr` out 3: target engine for dispatch.
- `in_word` out 83: {x[9:0], y[8:0], re[31:0], im[31:0]}.
- `latch_en` out 1: one-cycle dispatch strobe.
- `req_ack` out NUM_ENGINES: one-hot result grant.
- `pix_valid` out 1, `pix_ready` in 1: result handshake.
- `pix_x` out 10, `pix_y` out 9, `pix_itr` out 8: result payload.
- `busy` out 1: frame in progress.
- `done` out 1: frame complete; held until the next accepted `start`.

## Operation
- **Reset.** On `eRST`, all outputs are 0: `latch_en`, `req_ack`, `engine_addr`, `in_word`, `pix_*`, `busy`, `done`. The FSM goes to IDLE, and all counters and the `launched` mask are cleared. A reset mid-frame abandons the frame. Engines share `eRST`.
- **FSM states:** IDLE, SCAN, DISP, ACK, REL, DONE.
- **IDLE/DONE.**
  - When `start`=1: latch `re_start`, `im_start` and `step`; set x=y=0, cur_re=`re_start`, cur_im=`im_start`; set `busy`=1 and `done`=0; go to SCAN.
- **SCAN.** Priority is collection first, then dispatch.
  - **Collect:** if any `service_req` bit is set and the output register is empty (or drains this cycle), grant by round-robin starting at index rr_ptr. Drive `req_ack` one-hot, set rr_ptr = grant+1 (mod NUM_ENGINES), go to ACK.
  - **Dispatch:** else, if pixels remain and some engine k has `available[k]` & ~`launched[k]`, pick the lowest such k. Register `engine_addr`=k and `in_word`={x, y, cur_re, cur_im}, and set `latch_en`=1. Go to DISP.
  - Else stay in SCAN.
  - Go to DONE (`busy`=0, `done`=1) once all X_PIXELS×Y_PIXELS pixels are dispatched and the outstanding count is 0.
- **DISP** (one cycle, `latch_en`=1).
  - Set `launched[k]`=1 and increment outstanding.
  - Advance the raster: x+1 and cur_re += step. When x = X_PIXELS−1: x=0, cur_re=re_start, y+1, cur_im −= step.
  - Next cycle `latch_en`=0; return to SCAN.
- **launched[k]** clears on the first cycle `available[k]`=0 is observed. This blocks double dispatch during the one-cycle window before the engine drops `available`.
- **ACK** (one cycle, `req_ack` one-hot high).
  - Capture `result_bus` into the output register: pix_x=[26:17], pix_y=[16:8], pix_itr=[7:0]. Set `pix_valid`=1 and decrement outstanding.
  - Go to REL.
- **REL** (one cycle): `req_ack`=0 and `latch_en`=0. This lets the engine return to idle, which requires both low. Return to SCAN.
- **Output port.** `pix_valid` stays high until `pix_valid`&`pix_ready`. Payload is stable while `pix_valid`=1 and not accepted.
- **Arithmetic.** cur_re and cur_im are 32-bit two's complement and wrap with no saturation. The outstanding counter is 4 bits and never exceeds NUM_ENGINES.
- **Illegal states** decode to IDLE.

## Timing
- Dispatch occupies 2 cycles (SCAN, DISP), so a fully idle array fills at 1 engine per 2 cycles.
- Collection occupies 3 cycles (SCAN, ACK, REL). `req_ack` is high for exactly 1 cycle.
- `latch_en` is never high for 2 consecutive cycles and is never high in ACK or REL.
- At most one `req_ack` bit is high at a time; `req_ack` and `latch_en` are never high together.
- A `start` while `busy`=1 is ignored.
- Back-pressure: if `pix_ready`=0 with `pix_valid`=1, collection stalls; dispatch continues.

## Test plan
- **Minimal frame.** NUM_ENGINES=1, X_PIXELS=2, Y_PIXELS=2, re_start=0xFE000000, im_start=0x01000000, step=0x00800000. Response: 4 dispatches with re/im sequence (FE000000,01000000), (FE800000,01000000), (FE000000,00800000), (FE800000,00800000); 4 pixels out; then `done`=1 and `busy`=0.
- **Fill order.** 8 engines all available at start. Response: dispatches to addresses 0,1,…,7 on alternate cycles; no address repeats before its `available` drops.
- **Simultaneous requests.** `service_req`=0b00100100 with rr_ptr=0. Response: grant engine 2, then engine 5; each `req_ack` lasts 1 cycle and is followed by 1 REL cycle with `latch_en`=0.
- **Back-pressure.** Hold `pix_ready`=0 for 20 cycles while 3 engines request. Response: exactly 1 ACK; payload stable; the remaining acks occur only after acceptance.
- **Raster wrap.** X_PIXELS=3. Response: x sequence 0,1,2,0 with y incrementing on wrap; cur_re resets to re_start; cur_im decreases by `step`.
- **Reset mid-frame.** Assert `eRST` during ACK. Response: next cycle all outputs are 0 and FSM is IDLE; a new `start` produces a complete frame.
